perf_counter_bank: RTL and testbench

Parametrised multi-section performance counter, the next generation of the fixed 8-section Avalon performance counter in the Nios II system. Each section measures elapsed clock cycles while running and counts how often it is started. It is read and controlled from the CPU over a single Avalon-MM slave. Beyond the previous generation it adds a configurable section count and counter widths, atomic 64-bit time reads via a high-word snapshot, sticky overflow flags, and a selectable wrap/saturate mode.

---
 rtl/perf_counter_pkg.sv | 21 ++
 rtl/perf_counter_section.sv | 114 +++++++++++
 rtl/perf_counter_bank.sv | 97 +++++++++
 tb/tb_perf_counter_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_counter_pkg.sv
// Register-map constants and status layout shared by the performance counter bank.
package perf_counter_pkg;

    localparam int MAX_SECTIONS = 16;

    localparam logic [1:0] OFS_TIME_LO = 2'd0;
    localparam logic [1:0] OFS_TIME_HI = 2'd1;
    localparam logic [1:0] OFS_EVENT   = 2'd2;
    localparam logic [1:0] OFS_STATUS  = 2'd3;

    localparam int STS_RUNNING   = 0;
    localparam int STS_TIME_OVF  = 1;
    localparam int STS_EVENT_OVF = 2;

    typedef struct packed {
        logic event_ovf;
        logic time_ovf;
        logic running;
    } sec_status_t;

endpackage

// File: rtl/perf_counter_section.sv
// One measurement section: enable, time and event counters, high-word shadow and sticky overflow flags.
module perf_counter_section
    import perf_counter_pkg::*;
#(
    parameter int TIME_WIDTH  = 64,
    parameter int EVENT_WIDTH = 32,
    parameter bit SATURATE    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_global_reset,
    input  logic        i_global_enable,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_capture,
    input  logic        i_clr_time_ovf,
    input  logic        i_clr_event_ovf,
    input  logic [1:0]  i_offset,
    output logic        o_running,
    output logic [31:0] o_rdata
);

    logic [TIME_WIDTH-1:0]  r_time;
    logic [EVENT_WIDTH-1:0] r_event;
    logic [31:0]            r_shadow;
    logic                   r_en;
    logic                   r_time_ovf;
    logic                   r_event_ovf;

    logic                   w_time_inc;
    logic                   w_event_inc;
    logic                   w_time_max;
    logic                   w_event_max;
    logic [63:0]            w_time64;
    sec_status_t            w_status;

    function automatic logic [TIME_WIDTH-1:0] time_next(input logic [TIME_WIDTH-1:0] v);
        return (SATURATE && (&v)) ? v : v + 1'b1;
    endfunction

    function automatic logic [EVENT_WIDTH-1:0] event_next(input logic [EVENT_WIDTH-1:0] v);
        return (SATURATE && (&v)) ? v : v + 1'b1;
    endfunction

    assign w_time_inc  = r_en & i_global_enable;
    assign w_event_inc = i_start & i_global_enable;
    assign w_time_max  = &r_time;
    assign w_event_max = &r_event;
    assign w_time64    = 64'(r_time);

    assign w_status.event_ovf = r_event_ovf;
    assign w_status.time_ovf  = r_time_ovf;
    assign w_status.running   = r_en;
    assign o_running          = r_en;

    // Counting uses the enable as it stood before this edge, so a stop keeps its own cycle's count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_time      <= '0;
            r_event     <= '0;
            r_shadow    <= '0;
            r_en        <= 1'b0;
            r_time_ovf  <= 1'b0;
            r_event_ovf <= 1'b0;
        end else if (i_global_reset) begin
            r_time      <= '0;
            r_event     <= '0;
            r_shadow    <= '0;
            r_en        <= 1'b0;
            r_time_ovf  <= 1'b0;
            r_event_ovf <= 1'b0;
        end else begin
            if (i_stop) begin
                r_en <= 1'b0;
            end else if (i_start) begin
                r_en <= 1'b1;
            end

            if (w_time_inc) begin
                r_time <= time_next(r_time);
            end
            if (w_event_inc) begin
                r_event <= event_next(r_event);
            end

            // A new overflow wins over a clear arriving in the same cycle.
            if (w_time_inc && w_time_max) begin
                r_time_ovf <= 1'b1;
            end else if (i_clr_time_ovf) begin
                r_time_ovf <= 1'b0;
            end
            if (w_event_inc && w_event_max) begin
                r_event_ovf <= 1'b1;
            end else if (i_clr_event_ovf) begin
                r_event_ovf <= 1'b0;
            end

            if (i_capture) begin
                r_shadow <= w_time64[63:32];
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_offset)
            OFS_TIME_LO: o_rdata = w_time64[31:0];
            OFS_TIME_HI: o_rdata = r_shadow;
            OFS_EVENT:   o_rdata = 32'(r_event);
            default:     o_rdata = {29'b0, w_status};
        endcase
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Avalon-MM performance counter bank: address decode, NUM_SECTIONS section instances and registered read mux.
module perf_counter_bank
    import perf_counter_pkg::*;
#(
    parameter int NUM_SECTIONS = 8,
    parameter int TIME_WIDTH   = 64,
    parameter int EVENT_WIDTH  = 32,
    parameter bit SATURATE     = 1'b0,
    parameter int ADDR_WIDTH   = $clog2(NUM_SECTIONS * 4)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  begintransfer,
    input  logic                  write,
    input  logic                  read,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata
);

    logic                                w_wr;
    logic                                w_rd;
    logic [ADDR_WIDTH-1:0]               w_sec;
    logic [1:0]                          w_ofs;
    logic                                w_global_reset;
    logic                                w_global_enable;
    logic [NUM_SECTIONS-1:0]             w_hit;
    logic [NUM_SECTIONS-1:0]             w_start;
    logic [NUM_SECTIONS-1:0]             w_stop;
    logic [NUM_SECTIONS-1:0]             w_capture;
    logic [NUM_SECTIONS-1:0]             w_clr_tovf;
    logic [NUM_SECTIONS-1:0]             w_clr_eovf;
    logic [NUM_SECTIONS-1:0]             w_running;
    logic [NUM_SECTIONS-1:0][31:0]       w_sec_rdata;
    logic [31:0]                         w_rdata;
    logic [31:0]                         r_readdata;
    logic                                w_unused_wdata;

    assign w_wr           = write & begintransfer;
    assign w_rd           = read & begintransfer;
    assign w_sec          = address >> 2;
    assign w_ofs          = address[1:0];
    assign w_unused_wdata = ^writedata[31:3];

    // Section 0 is the master gate: its own start strobe already opens the gate in that cycle.
    assign w_global_reset  = w_wr & w_hit[0] & (w_ofs == OFS_TIME_LO) & writedata[0];
    assign w_global_enable = w_running[0] | w_start[0];

    for (genvar g = 0; g < NUM_SECTIONS; g++) begin : g_sec
        assign w_hit[g]      = (w_sec == ADDR_WIDTH'(g));
        assign w_stop[g]     = w_wr & w_hit[g] & (w_ofs == OFS_TIME_LO);
        assign w_start[g]    = w_wr & w_hit[g] & (w_ofs == OFS_TIME_HI);
        assign w_capture[g]  = w_rd & w_hit[g] & (w_ofs == OFS_TIME_LO);
        assign w_clr_tovf[g] = w_wr & w_hit[g] & (w_ofs == OFS_STATUS) & writedata[STS_TIME_OVF];
        assign w_clr_eovf[g] = w_wr & w_hit[g] & (w_ofs == OFS_STATUS) & writedata[STS_EVENT_OVF];

        perf_counter_section #(
            .TIME_WIDTH  (TIME_WIDTH),
            .EVENT_WIDTH (EVENT_WIDTH),
            .SATURATE    (SATURATE)
        ) u_sec (
            .clk             (clk),
            .reset           (reset),
            .i_global_reset  (w_global_reset),
            .i_global_enable (w_global_enable),
            .i_start         (w_start[g]),
            .i_stop          (w_stop[g]),
            .i_capture       (w_capture[g]),
            .i_clr_time_ovf  (w_clr_tovf[g]),
            .i_clr_event_ovf (w_clr_eovf[g]),
            .i_offset        (w_ofs),
            .o_running       (w_running[g]),
            .o_rdata         (w_sec_rdata[g])
        );
    end

    // Unimplemented section indices fall through to zero.
    always_comb begin
        w_rdata = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (w_hit[s]) begin
                w_rdata = w_sec_rdata[s];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomised and directed bench for perf_counter_bank against a register-level behavioural model.
`timescale 1ns/1ps
module tb_perf_counter_bank;

    localparam int N  = 5;
    localparam int TW = 33;
    localparam int EW = 3;
    localparam int AW = $clog2(N * 4);
    localparam bit SAT = 1'b0;
    localparam longint unsigned TMAX = (64'd1 << TW) - 64'd1;
    localparam int unsigned EMAX = (32'd1 << EW) - 32'd1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic          begintransfer;
    logic          write;
    logic          read;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    perf_counter_bank #(
        .NUM_SECTIONS (N),
        .TIME_WIDTH   (TW),
        .EVENT_WIDTH  (EW),
        .SATURATE     (SAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .begintransfer (begintransfer),
        .write         (write),
        .read          (read),
        .writedata     (writedata),
        .readdata      (readdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint unsigned m_time   [N];
    int unsigned     m_event  [N];
    logic [31:0]     m_shadow [N];
    bit              m_en     [N];
    bit              m_tovf   [N];
    bit              m_eovf   [N];

    logic [31:0] got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < N; s++) begin
            m_time[s] = 0; m_event[s] = 0; m_shadow[s] = 0;
            m_en[s] = 0; m_tovf[s] = 0; m_eovf[s] = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input int sec, input int ofs);
        if (sec >= N) return 32'h0;
        case (ofs)
            0:       return 32'(m_time[sec]);
            1:       return m_shadow[sec];
            2:       return m_event[sec];
            default: return {29'b0, m_eovf[sec], m_tovf[sec], m_en[sec]};
        endcase
    endfunction

    // One clock edge of the register map's behaviour, from pre-edge state.
    function automatic void model_step(input bit wr, input bit rd, input int sec, input int ofs,
                                       input logic [31:0] wd);
        bit genable;
        bit hit;
        bit start;
        bit stop;
        if (wr && sec == 0 && ofs == 0 && wd[0]) begin
            model_reset();
            return;
        end
        genable = m_en[0] || (wr && sec == 0 && ofs == 1);
        for (int s = 0; s < N; s++) begin
            hit   = (sec == s);
            start = wr && hit && ofs == 1;
            stop  = wr && hit && ofs == 0;
            if (rd && hit && ofs == 0) m_shadow[s] = 32'(m_time[s] >> 32);
            if (wr && hit && ofs == 3 && wd[1]) m_tovf[s] = 0;
            if (wr && hit && ofs == 3 && wd[2]) m_eovf[s] = 0;
            if (m_en[s] && genable) begin
                if (m_time[s] == TMAX) begin
                    m_tovf[s] = 1;
                    m_time[s] = SAT ? TMAX : 0;
                end else begin
                    m_time[s] = m_time[s] + 1;
                end
            end
            if (start && genable) begin
                if (m_event[s] == EMAX) begin
                    m_eovf[s]  = 1;
                    m_event[s] = SAT ? EMAX : 0;
                end else begin
                    m_event[s] = m_event[s] + 1;
                end
            end
            if (stop) m_en[s] = 0;
            else if (start) m_en[s] = 1;
        end
    endfunction

    task automatic bus(input bit w, input bit r, input bit bt, input int sec, input int ofs,
                       input logic [31:0] wd, output logic [31:0] obs);
        logic [31:0] exp;
        @(negedge clk);
        write = w; read = r; begintransfer = bt; writedata = wd;
        address = AW'(sec * 4 + ofs);
        exp = model_read(sec, ofs);
        @(posedge clk);
        model_step(w && bt, r && bt, sec, ofs, wd);
        #1;
        obs = readdata;
        check($sformatf("rd_s%0d_o%0d", sec, ofs), obs, exp);
        write = 1'b0; read = 1'b0; begintransfer = 1'b0;
    endtask

    task automatic wr_reg(input int sec, input int ofs, input logic [31:0] wd);
        logic [31:0] obs;
        bus(1'b1, 1'b0, 1'b1, sec, ofs, wd, obs);
    endtask

    task automatic rd_reg(input int sec, input int ofs, output logic [31:0] obs);
        bus(1'b0, 1'b1, 1'b1, sec, ofs, 32'h0, obs);
    endtask

    task automatic idle(input int n);
        logic [31:0] obs;
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 0, 3, 32'h0, obs);
    endtask

    initial begin
        int sec;
        int ofs;
        int kind;
        bit w;
        bit r;
        bit bt;
        logic [31:0] wd;

        reset = 1'b1; write = 1'b0; read = 1'b0; begintransfer = 1'b0;
        address = '0; writedata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset_readdata", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Section 0 alone for 100 cycles
        wr_reg(0, 1, 0);
        idle(99);
        wr_reg(0, 0, 0);
        rd_reg(0, 0, got); check("s0_time_lo", got, 32'd100);
        rd_reg(0, 1, got); check("s0_time_hi", got, 32'd0);
        rd_reg(0, 2, got); check("s0_event", got, 32'd1);

        // Section 3 is gated by section 0
        wr_reg(3, 1, 0);
        idle(50);
        rd_reg(3, 0, got); check("s3_gated_time", got, 32'd0);
        rd_reg(3, 2, got); check("s3_gated_event", got, 32'd0);
        wr_reg(0, 1, 0);
        idle(19);
        rd_reg(3, 0, got); check("s3_time_20", got, 32'd20);

        // Coherent 64-bit read across a carry into bit 32
        force dut.g_sec[1].u_sec.r_time = 33'h0_FFFF_FFFE;
        idle(1);
        release dut.g_sec[1].u_sec.r_time;
        m_time[1] = 64'h0_FFFF_FFFE;
        wr_reg(1, 1, 0);
        rd_reg(1, 0, got); check("s1_lo_pre_carry", got, 32'hFFFF_FFFE);
        idle(4);
        rd_reg(1, 1, got); check("s1_hi_shadow", got, 32'h0);
        rd_reg(1, 0, got);
        rd_reg(1, 1, got); check("s1_hi_after_carry", got, 32'h1);
        wr_reg(1, 0, 0);

        // Time overflow wraps, sets sticky flag, W1C clears it
        force dut.g_sec[2].u_sec.r_time = 33'h1_FFFF_FFFC;
        idle(1);
        release dut.g_sec[2].u_sec.r_time;
        m_time[2] = 64'h1_FFFF_FFFC;
        wr_reg(2, 1, 0);
        idle(6);
        rd_reg(2, 3, got); check("s2_status_ovf", got, 32'h3);
        rd_reg(2, 0, got); check("s2_time_wrapped", got, 32'd3);
        wr_reg(2, 3, 32'h2);
        rd_reg(2, 3, got); check("s2_tovf_cleared", got, 32'h1);

        // Event overflow after 8 starts of a 3-bit counter
        for (int i = 0; i < 7; i++) wr_reg(2, 1, 0);
        rd_reg(2, 2, got); check("s2_event_wrapped", got, 32'h0);
        rd_reg(2, 3, got); check("s2_status_eovf", got, 32'h5);
        wr_reg(2, 3, 32'h4);
        rd_reg(2, 3, got); check("s2_eovf_cleared", got, 32'h1);

        // Unimplemented sections and transfers without begintransfer
        wr_reg(6, 1, 0);
        rd_reg(6, 0, got); check("s6_absent", got, 32'h0);
        rd_reg(5, 3, got); check("s5_absent", got, 32'h0);
        bus(1'b1, 1'b0, 1'b0, 4, 1, 32'h0, got);
        rd_reg(4, 3, got); check("s4_no_bt_start", got, 32'h0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            sec  = $urandom_range(0, 7);
            ofs  = $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            w    = (kind < 5);
            r    = (kind >= 5) && (kind < 9);
            bt   = ($urandom_range(0, 7) != 0);
            wd   = $urandom;
            if (sec == 0 && ofs == 0 && $urandom_range(0, 9) != 0) wd[0] = 1'b0;
            bus(w, r, bt, sec, ofs, wd, got);
        end

        // Global reset clears every section
        wr_reg(0, 1, 0); wr_reg(1, 1, 0); wr_reg(3, 1, 0); wr_reg(4, 1, 0);
        idle(10);
        wr_reg(0, 0, 32'h1);
        for (int s = 0; s < N; s++) begin
            for (int o = 0; o < 4; o++) begin
                rd_reg(s, o, got);
                check($sformatf("greset_s%0d_o%0d", s, o), got, 32'h0);
            end
        end

        // Asynchronous reset in the middle of a run
        wr_reg(0, 1, 0); wr_reg(2, 1, 0);
        idle(5);
        rd_reg(2, 0, got);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_readdata", readdata, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        rd_reg(2, 0, got); check("post_reset_time", got, 32'h0);
        rd_reg(0, 3, got); check("post_reset_status", got, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
